// File: rtl/mxv_frame_sequencer.sv
// Front-end sequencer for the MxV datapath: parses UART frames, loads the
// matrix/vector FIFOs, launches the multiply and drains the results.
module mxv_frame_sequencer #(
    parameter int              DW      = 8,
    parameter int              MAX_N   = 8,
    parameter logic [DW-1:0]   HDR     = 8'hFE,
    parameter logic [DW-1:0]   TAIL    = 8'hEF,
    parameter int              TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rcv,
    input  logic [DW-1:0] data,
    output logic          push_matrix,
    output logic          push_vector,
    output logic [DW-1:0] wr_data,
    output logic [3:0]    n_size,
    output logic          start,
    input  logic          proc_done,
    output logic          pop_result,
    input  logic          tx_ready,
    output logic          busy,
    output logic          error
);

    localparam int CW = $clog2(MAX_N * MAX_N) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        GET_N,
        LOAD_MAT,
        LOAD_VEC,
        GET_TAIL,
        RUN,
        WAIT_DONE,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] nn;
    logic [CW-1:0] nn_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic [3:0]    n_nx;
    logic          err_nx;
    logic          pm_nx;
    logic          pv_nx;
    logic [DW-1:0] wd_nx;

    logic          size_ok;
    logic [CW-1:0] n_last;
    logic [CW-1:0] nn_last;
    logic [CW-1:0] n_in;
    logic          post_load;

    assign size_ok   = (data >= DW'(2)) && (data <= DW'(MAX_N));
    assign n_in      = CW'(data[3:0]);
    assign n_last    = CW'(n_size) - CW'(1);
    assign nn_last   = nn - CW'(1);
    assign post_load = (state == RUN) || (state == WAIT_DONE) ||
                       (state == DRAIN);
    assign busy      = (state != IDLE);

    // Next-state, counters and strobe decisions for the frame FSM.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        nn_nx      = nn;
        timer_nx   = timer;
        n_nx       = n_size;
        err_nx     = error;
        pm_nx      = 1'b0;
        pv_nx      = 1'b0;
        wd_nx      = wr_data;
        start      = 1'b0;
        pop_result = 1'b0;
        unique case (state)
            IDLE: begin
                if (rcv && data == HDR) begin
                    state_nx = GET_N;
                    err_nx   = 1'b0;
                end
            end
            GET_N: begin
                if (rcv) begin
                    if (size_ok) begin
                        n_nx     = data[3:0];
                        nn_nx    = n_in * n_in;
                        cnt_nx   = '0;
                        state_nx = LOAD_MAT;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            LOAD_MAT: begin
                if (rcv) begin
                    pm_nx = 1'b1;
                    wd_nx = data;
                    if (cnt == nn_last) begin
                        cnt_nx   = '0;
                        state_nx = LOAD_VEC;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            LOAD_VEC: begin
                if (rcv) begin
                    pv_nx = 1'b1;
                    wd_nx = data;
                    if (cnt == n_last) begin
                        cnt_nx   = '0;
                        state_nx = GET_TAIL;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            GET_TAIL: begin
                if (rcv) begin
                    if (data == TAIL) begin
                        state_nx = RUN;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            RUN: begin
                start    = 1'b1;
                timer_nx = '0;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (proc_done) begin
                    cnt_nx   = '0;
                    state_nx = DRAIN;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            DRAIN: begin
                if (tx_ready) begin
                    pop_result = 1'b1;
                    if (cnt == n_last) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // A byte arriving after the frame is complete is a protocol error.
        if (rcv && post_load) begin
            err_nx = 1'b1;
        end
    end

    // State, counters and registered push strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            nn          <= '0;
            timer       <= '0;
            n_size      <= '0;
            error       <= 1'b0;
            push_matrix <= 1'b0;
            push_vector <= 1'b0;
            wr_data     <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            nn          <= nn_nx;
            timer       <= timer_nx;
            n_size      <= n_nx;
            error       <= err_nx;
            push_matrix <= pm_nx;
            push_vector <= pv_nx;
            wr_data     <= wd_nx;
        end
    end

endmodule

// File: tb/tb_mxv_frame_sequencer.sv
// Directed bench for mxv_frame_sequencer: frame parsing, error paths,
// timeout, drain handshake and mid-frame reset.
module tb_mxv_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rcv;
    logic [7:0] data;
    logic       push_matrix;
    logic       push_vector;
    logic [7:0] wr_data;
    logic [3:0] n_size;
    logic       start;
    logic       proc_done;
    logic       pop_result;
    logic       tx_ready;
    logic       busy;
    logic       error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int pop_cnt = 0;
    int overlap = 0;
    logic [7:0] mat_q[$];
    logic [7:0] vec_q[$];
    logic [7:0] fbuf[0:127];

    mxv_frame_sequencer dut (
        .clk(clk), .rst(rst), .rcv(rcv), .data(data),
        .push_matrix(push_matrix), .push_vector(push_vector),
        .wr_data(wr_data), .n_size(n_size), .start(start),
        .proc_done(proc_done), .pop_result(pop_result),
        .tx_ready(tx_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (push_matrix) mat_q.push_back(wr_data);
        if (push_vector) vec_q.push_back(wr_data);
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (pop_result) pop_cnt++;
        if (int'(push_matrix) + int'(push_vector) +
            int'(pop_result) + int'(start) > 1) overlap++;
    end

    task automatic clear_logs();
        mat_q.delete();
        vec_q.delete();
        start_cnt = 0;
        pop_cnt = 0;
        overlap = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rcv = 1'b0;
        proc_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic build_frame(input int n, input int base,
                               input logic [7:0] tail);
        fbuf[0] = 8'hFE;
        fbuf[1] = 8'(n);
        for (int i = 0; i < n * n + n; i++) fbuf[2 + i] = 8'(base + i);
        fbuf[2 + n * n + n] = tail;
    endtask

    task automatic send_bytes(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rcv = 1'b1;
            data = fbuf[i];
        end
        @(posedge clk); #1;
        rcv = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        proc_done = 1'b1;
        @(posedge clk); #1;
        proc_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rcv = 1'b0; data = 8'h00;
        proc_done = 1'b0; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, error, start, push_matrix, push_vector, pop_result} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=000000",
                {busy, error, start, push_matrix, push_vector, pop_result});
        end
        total++;
        if (n_size !== 4'd0) begin
            bad++; $display("FAIL reset_n_size got=%0d want=0", n_size);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        pulse_done();
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || pop_cnt !== 0) begin
            bad++;
            $display("FAIL idle_done_ignored busy=%b pops=%0d want 0/0", busy, pop_cnt);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        clear_logs();
        tx_ready = 1'b1;
        build_frame(2, 1, 8'hEF);
        send_bytes(9);
        repeat (3) @(negedge clk);
        total++;
        if (mat_q.size() !== 4 || vec_q.size() !== 2) begin
            bad++;
            $display("FAIL basic_push_counts got=%0d/%0d want=4/2", mat_q.size(), vec_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (mat_q[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL basic_mat[%0d] got=%h want=%h", i, mat_q[i], 8'(i + 1));
                end
            end
            total++;
            if (vec_q[0] !== 8'd5 || vec_q[1] !== 8'd6) begin
                bad++;
                $display("FAIL basic_vec got=%h,%h want=05,06", vec_q[0], vec_q[1]);
            end
        end
        total++;
        if (start_cnt !== 1 || n_size !== 4'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_launch start=%0d n=%0d busy=%b want 1/2/1", start_cnt, n_size, busy);
        end
        total++;
        if (pop_cnt !== 0) begin
            bad++; $display("FAIL basic_no_early_pop got=%0d want=0", pop_cnt);
        end
        pulse_done();
        begin
            logic p1;
            logic p2;
            @(negedge clk); p1 = pop_result;
            @(negedge clk); p2 = pop_result;
            total++;
            if ({p1, p2} !== 2'b11) begin
                bad++; $display("FAIL basic_pop_seq got=%b want=11", {p1, p2});
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || pop_cnt !== 2 || error !== 1'b0) begin
            bad++;
            $display("FAIL basic_end busy=%b pops=%0d err=%b want 0/2/0", busy, pop_cnt, error);
        end
        total++;
        if (overlap !== 0) begin
            bad++; $display("FAIL strobe_overlap got=%0d want=0", overlap);
        end
    endtask

    task automatic test_bad_size();
        do_reset();
        clear_logs();
        fbuf[0] = 8'hFE;
        fbuf[1] = 8'h09;
        send_bytes(2);
        @(negedge clk);
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || mat_q.size() !== 0) begin
            bad++;
            $display("FAIL bad_size err=%b busy=%b push=%0d want 1/0/0", error, busy, mat_q.size());
        end
        fbuf[0] = 8'hFE;
        send_bytes(1);
        @(negedge clk);
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hdr_clears_err err=%b busy=%b want 0/1", error, busy);
        end
    endtask

    task automatic test_bad_tail();
        do_reset();
        clear_logs();
        build_frame(2, 1, 8'h00);
        send_bytes(9);
        repeat (2) @(negedge clk);
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || start_cnt !== 0) begin
            bad++;
            $display("FAIL bad_tail err=%b busy=%b start=%0d want 1/0/0", error, busy, start_cnt);
        end
        total++;
        if (mat_q.size() !== 4 || vec_q.size() !== 2) begin
            bad++;
            $display("FAIL bad_tail_pushes got=%0d/%0d want=4/2", mat_q.size(), vec_q.size());
        end
    endtask

    task automatic test_timeout();
        bit seen_a;
        bit seen_b;
        int k;
        seen_a = 1'b0;
        seen_b = 1'b0;
        do_reset();
        clear_logs();
        tx_ready = 1'b0;
        build_frame(2, 1, 8'hEF);
        send_bytes(9);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            k = cyc - start_cyc;
            if (start_cnt == 1 && k == 1023) begin
                seen_a = 1'b1;
                total++;
                if (error !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_early err=%b busy=%b want 0/1", error, busy);
                end
            end
            if (start_cnt == 1 && k == 1025) begin
                seen_b = 1'b1;
                total++;
                if (error !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_fire err=%b busy=%b want 1/0", error, busy);
                end
            end
        end
        total++;
        if (!(seen_a && seen_b) || pop_cnt !== 0) begin
            bad++;
            $display("FAIL timeout_window seen=%b%b pops=%0d want 11/0", seen_a, seen_b, pop_cnt);
        end
    endtask

    task automatic test_drain_stall();
        logic p;
        do_reset();
        clear_logs();
        tx_ready = 1'b0;
        build_frame(2, 1, 8'hEF);
        send_bytes(9);
        fbuf[0] = 8'h11;
        send_bytes(1);
        @(negedge clk);
        total++;
        if (error !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stray_byte err=%b busy=%b want 1/1", error, busy);
        end
        pulse_done();
        tx_ready = 1'b1;
        @(negedge clk); p = pop_result;
        total++;
        if (p !== 1'b1) begin
            bad++; $display("FAIL drain_pop0 got=%b want=1", p);
        end
        @(posedge clk); #1; tx_ready = 1'b0;
        @(negedge clk); p = pop_result;
        total++;
        if (p !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL drain_stall pop=%b busy=%b want 0/1", p, busy);
        end
        @(posedge clk); #1; tx_ready = 1'b1;
        @(negedge clk); p = pop_result;
        total++;
        if (p !== 1'b1) begin
            bad++; $display("FAIL drain_pop1 got=%b want=1", p);
        end
        @(posedge clk); #1; tx_ready = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pop_cnt !== 2 || error !== 1'b1) begin
            bad++;
            $display("FAIL drain_end busy=%b pops=%0d err=%b want 0/2/1", busy, pop_cnt, error);
        end
    endtask

    task automatic test_max_n();
        do_reset();
        clear_logs();
        tx_ready = 1'b1;
        build_frame(8, 16, 8'hEF);
        send_bytes(75);
        repeat (2) @(negedge clk);
        total++;
        if (mat_q.size() !== 64 || vec_q.size() !== 8 || n_size !== 4'd8 || start_cnt !== 1) begin
            bad++;
            $display("FAIL max_n mat=%0d vec=%0d n=%0d start=%0d want 64/8/8/1",
                mat_q.size(), vec_q.size(), n_size, start_cnt);
        end else begin
            total++;
            if (mat_q[63] !== 8'h4F || vec_q[7] !== 8'h57) begin
                bad++;
                $display("FAIL max_n_data got=%h,%h want=4f,57", mat_q[63], vec_q[7]);
            end
        end
        pulse_done();
        repeat (10) @(negedge clk);
        total++;
        if (pop_cnt !== 8 || busy !== 1'b0) begin
            bad++; $display("FAIL max_n_drain pops=%0d busy=%b want 8/0", pop_cnt, busy);
        end
    endtask

    task automatic test_hdr_as_data();
        do_reset();
        clear_logs();
        build_frame(2, 1, 8'hEF);
        fbuf[2] = 8'hFE;
        fbuf[6] = 8'hFE;
        send_bytes(9);
        repeat (2) @(negedge clk);
        total++;
        if (mat_q.size() !== 4 || vec_q.size() !== 2 || start_cnt !== 1) begin
            bad++;
            $display("FAIL hdr_data counts got=%0d/%0d/%0d want 4/2/1",
                mat_q.size(), vec_q.size(), start_cnt);
        end else begin
            total++;
            if (mat_q[0] !== 8'hFE || mat_q[1] !== 8'h02 || vec_q[0] !== 8'hFE) begin
                bad++;
                $display("FAIL hdr_data bytes got=%h,%h,%h want fe,02,fe",
                    mat_q[0], mat_q[1], vec_q[0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        clear_logs();
        tx_ready = 1'b1;
        build_frame(2, 1, 8'hEF);
        send_bytes(5);
        total++;
        if (push_matrix !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_pending push=%b busy=%b want 1/1", push_matrix, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, error, start, push_matrix, push_vector, pop_result} !== 6'b0 ||
            n_size !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b n=%0d want=000000 n=0",
                {busy, error, start, push_matrix, push_vector, pop_result}, n_size);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        send_bytes(9);
        pulse_done();
        repeat (4) @(negedge clk);
        total++;
        if (mat_q.size() !== 4 || vec_q.size() !== 2 || start_cnt !== 1 ||
            pop_cnt !== 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_refresh mat=%0d vec=%0d start=%0d pops=%0d busy=%b want 4/2/1/2/0",
                mat_q.size(), vec_q.size(), start_cnt, pop_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_size();
        test_bad_tail();
        test_timeout();
        test_drain_stall();
        test_max_n();
        test_hdr_as_data();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
